ram_stream_reader: RTL
======================

// Module: ram_stream_reader
// PURPOSE
//  Read-side client for the single-port sync-read block RAMs (q registered, 1-cycle latency).
//  On a start pulse, reads COUNT consecutive words from BASE and streams them out on valid/ready.
//  Accounts for RAM read latency and absorbs downstream backpressure in an internal FIFO.
//  Sits between a video/sprite RAM and its consumer (line buffer or sprite engine).
// PARAMETERS
//  addr_width_g  11  RAM address width; addresses wrap modulo 2**addr_width_g
//  data_width_g  8   RAM word width
//  fifo_depth_g  4   skid FIFO entries; must be >=3 for 1 word/cycle throughput
// PORTS
//  clock        in   1             single clock, rising edge
//  reset        in   1             synchronous, active-high
//  start        in   1             begin a burst; sampled only in IDLE
//  base_addr    in   addr_width_g  first word address, sampled with start
//  count        in   addr_width_g+1 words to read (0..2**addr_width_g), sampled with start
//  busy         out  1             high from cycle after start accepted until done pulse
//  done         out  1             1-cycle pulse: burst complete
//  ram_address  out  addr_width_g  to RAM address (RAM wren is tied low by the parent)
//  ram_q        in   data_width_g  from RAM q
//  out_data     out  data_width_g  streamed word
//  out_addr     out  addr_width_g  RAM address the word came from
//  out_last     out  1             qualifies the final word of the burst
//  out_valid    out  1             word available
//  out_ready    in   1             consumer accepts when out_valid & out_ready
// BEHAVIOUR
//  Reset (sync, active-high):
//   - Clears all state, FIFO and in-flight tracking; outputs go to 0.
//   - Reset mid-burst abandons the burst with no done pulse.
//  States:
//   - IDLE: start=1 latches base/count.
//     count=0 -> DONE; else -> READ.
//   - READ: issues one read per cycle while issued < count AND fifo_count + inflight < fifo_depth_g.
//     Moves to DRAIN after the last issue.
//   - DRAIN: waits until the last word has been accepted, then -> DONE.
//   - DONE: done=1 for exactly one cycle -> IDLE.
//  Issue and data timing:
//   - Issue cycle t: ram_address = base+n (mod 2**addr_width_g); ram_address holds its value when not issuing.
//   - ram_q is valid in cycle t+1 and is written into the FIFO at the end of t+1.
//   - out_valid can be high from cycle t+2.
//  Latency and throughput:
//   - Start high in cycle c0 -> first issue in c1 -> out_valid in c3.
//   - With out_ready held high, one word per cycle with no bubbles.
//  Outputs:
//   - out_data/out_addr/out_last come from the FIFO head and hold stable while out_valid & !out_ready.
//   - out_valid never drops without acceptance.
//   - out_last=1 only on word count-1.
//  Flow control and protocol:
//   - FIFO never overflows: the credit check counts in-flight reads. The FIFO cannot underflow (out_valid = !empty).
//   - Simultaneous push and pop in one cycle leaves fifo_count unchanged.
//   - start while busy is ignored.
//   - done and busy-deassert occur in the cycle after the last handshake.
//   - A new start is accepted no earlier than the cycle after done.
//   - count=0: no RAM read, no out_valid, done pulses 2 cycles after start (c2).
//  Width rules:
//   - issued and accepted counters are addr_width_g+1 bits, so count=2**addr_width_g reads the whole RAM once.
// TESTING
//  1. RAM[i]=i&0xFF, start base=0x010 count=4, out_ready=1 -> out_valid c3..c6, data 10,11,12,13; last on 13; done c7.
//  2. Same burst, out_ready toggled 1,0,0,1,...
//     -> data unchanged while stalled; no loss or duplication; ram_address stalls once FIFO+inflight=4.
//  3. base=0x7FE count=4 (addr_width_g=11) -> out_addr 7FE,7FF,000,001; data matches RAM.
//  4. count=0 -> no ram_address change, out_valid never high, done pulse at c2, busy low throughout.
//  5. start re-pulsed mid-burst -> ignored, original 4 words only.
//     Then reset mid-burst -> all outputs 0 next cycle, no done.
//     A following start works normally.
//  6. count=2048 full sweep with random out_ready -> 2048 words in order, exactly one out_last, one done.

Source files
------------

// File: rtl/ram_stream_reader_if.sv
// Bus bundle for ram_stream_reader: the RAM read port plus the outgoing word stream.
// Stream handshake: a word transfers on a rising clock edge where out_valid && out_ready; once
// out_valid is high it stays high, with out_data/out_addr/out_last stable, until that transfer.
interface ram_stream_reader_if #(
    parameter int addr_width_g = 11,
    parameter int data_width_g = 8
);
    logic [addr_width_g-1:0] ram_address;
    logic [data_width_g-1:0] ram_q;
    logic [data_width_g-1:0] out_data;
    logic [addr_width_g-1:0] out_addr;
    logic                    out_last;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output ram_address,
        input  ram_q,
        output out_data,
        output out_addr,
        output out_last,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  ram_address,
        output ram_q,
        input  out_data,
        input  out_addr,
        input  out_last,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Burst reader for a 1-cycle-latency sync-read RAM: issues COUNT reads from BASE and streams the
// words out through a small FIFO, issuing only when the FIFO has room for every read in flight.
module ram_stream_reader #(
    parameter int addr_width_g = 11,
    parameter int data_width_g = 8,
    parameter int fifo_depth_g = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [addr_width_g-1:0] base_addr,
    input  logic [addr_width_g:0]   count,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              dbg_state,
    ram_stream_reader_if.master     bus
);
    localparam int PW = (fifo_depth_g > 1) ? $clog2(fifo_depth_g) : 1;
    localparam int CW = $clog2(fifo_depth_g + 1) + 1;
    localparam int EW = 1 + addr_width_g + data_width_g;

    localparam logic [CW-1:0]         cnt_one_c = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]         ptr_one_c = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [addr_width_g:0] iss_one_c = {{addr_width_g{1'b0}}, 1'b1};
    localparam logic [CW-1:0]         depth_c   = CW'(fifo_depth_g);
    localparam logic [PW-1:0]         ptr_max_c = PW'(fifo_depth_g - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    zero_q, zero_d;
    logic [addr_width_g-1:0] base_q, base_d;
    logic [addr_width_g:0]   count_q, count_d;
    logic [addr_width_g:0]   issued_q, issued_d;
    logic [addr_width_g-1:0] hold_addr_q, hold_addr_d;
    logic                    inflight_q, inflight_d;
    logic [addr_width_g-1:0] rd_addr_q, rd_addr_d;
    logic                    rd_last_q, rd_last_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           fifo_count_q, fifo_count_d;
    logic [EW-1:0]           mem_q [fifo_depth_g];

    logic [addr_width_g-1:0] issue_addr;
    logic [addr_width_g:0]   issued_inc;
    logic                    credit_ok;
    logic                    issue;
    logic                    last_issue;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic [EW-1:0]           head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == ptr_max_c) begin
            return '0;
        end
        return p + ptr_one_c;
    endfunction

    // A read issued last cycle is still owed a FIFO slot, so it counts against the credit.
    assign issue_addr = base_q + issued_q[addr_width_g-1:0];
    assign issued_inc = issued_q + iss_one_c;
    assign credit_ok  = (fifo_count_q + {{(CW-1){1'b0}}, inflight_q}) < depth_c;
    assign issue      = (state_q == ST_READ) && (issued_q != count_q) && credit_ok;
    assign last_issue = issued_inc == count_q;
    assign fifo_empty = fifo_count_q == '0;
    assign push       = inflight_q;
    assign pop        = !fifo_empty && bus.out_ready;
    assign head       = fifo_empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        state_d      = state_q;
        zero_d       = zero_q;
        base_d       = base_q;
        count_d      = count_q;
        issued_d     = issued_q;
        hold_addr_d  = hold_addr_q;
        inflight_d   = issue;
        rd_addr_d    = rd_addr_q;
        rd_last_d    = rd_last_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    count_d  = count;
                    issued_d = '0;
                    if (count == '0) begin
                        // Empty burst spends two cycles in DONE so done lands two cycles after start.
                        state_d = ST_DONE;
                        zero_d  = 1'b1;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (issue) begin
                    issued_d = issued_inc;
                    if (last_issue) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && head[EW-1]) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (zero_q) begin
                    zero_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            hold_addr_d = issue_addr;
            rd_addr_d   = issue_addr;
            rd_last_d   = last_issue;
        end

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + cnt_one_c;
            2'b01:   fifo_count_d = fifo_count_q - cnt_one_c;
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            zero_q       <= 1'b0;
            base_q       <= '0;
            count_q      <= '0;
            issued_q     <= '0;
            hold_addr_q  <= '0;
            inflight_q   <= 1'b0;
            rd_addr_q    <= '0;
            rd_last_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            state_q      <= state_d;
            zero_q       <= zero_d;
            base_q       <= base_d;
            count_q      <= count_d;
            issued_q     <= issued_d;
            hold_addr_q  <= hold_addr_d;
            inflight_q   <= inflight_d;
            rd_addr_q    <= rd_addr_d;
            rd_last_q    <= rd_last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {rd_last_q, rd_addr_q, bus.ram_q};
        end
    end

    assign bus.ram_address = issue ? issue_addr : hold_addr_q;
    assign bus.out_valid   = !fifo_empty;
    assign bus.out_last    = head[EW-1];
    assign bus.out_addr    = head[EW-2:data_width_g];
    assign bus.out_data    = head[data_width_g-1:0];
    assign busy            = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done            = (state_q == ST_DONE) && !zero_q;
    assign dbg_state       = state_q;
endmodule
